// File: rtl/regfile_mux_n.sv
// Multi-port register file with optional zero register, write-to-read bypass,
// optional registered read ports and a sequenced clear engine.
module regfile_mux_n #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int REG_RD   = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  input  logic                 clr_req,
  output logic                 busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      clr_idx;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               wr_live;
  logic               wr_ok;
  logic [AW-1:0]      ra;
  logic [NRD*WIDTH-1:0] rd_comb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && clr_req)
        clr_idx <= '0;
      else if (state == CLEAR)
        clr_idx <= clr_idx + AW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (clr_idx == '1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  assign wr_live = wr_en && !busy;
  assign wr_ok   = wr_live && !((ZERO_REG != 0) && (wr_addr == '0));

  // The clear engine owns the array while busy; writes in that window are lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (busy) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_comb = '0;
    ra      = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      if ((ZERO_REG != 0) && (ra == '0))
        rd_comb[k*WIDTH +: WIDTH] = '0;
      else if (wr_live && (wr_addr == ra))
        rd_comb[k*WIDTH +: WIDTH] = wr_data;
      else
        rd_comb[k*WIDTH +: WIDTH] = mem[ra];
    end
  end

  if (REG_RD != 0) begin : g_reg_rd
    logic [NRD*WIDTH-1:0] rd_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_q <= '0;
      else          rd_q <= rd_comb;
    end
    assign rd_data = rd_q;
  end else begin : g_comb_rd
    assign rd_data = rd_comb;
  end

endmodule

// File: tb/tb_regfile_mux_n.sv
// Directed bench for regfile_mux_n: combinational and registered default
// configurations sharing stimulus, plus a small 4-port registered variant.
module tb_regfile_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        wr_en, clr_req;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data0, rd_data1;
  logic        busy0, busy1;

  logic        p_wr_en, p_clr_req, p_busy;
  logic [2:0]  p_wr_addr;
  logic [7:0]  p_wr_data;
  logic [11:0] p_rd_addr;
  logic [31:0] p_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_mux_n #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1), .REG_RD(0)) u_comb (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data0), .clr_req(clr_req), .busy(busy0)
  );

  regfile_mux_n #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1), .REG_RD(1)) u_reg (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data1), .clr_req(clr_req), .busy(busy1)
  );

  regfile_mux_n #(.WIDTH(8), .DEPTH(8), .NRD(4), .ZERO_REG(0), .REG_RD(1)) u_par (
    .clk(clk), .reset_n(reset_n), .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
    .rd_addr(p_rd_addr), .rd_data(p_rd_data), .clr_req(p_clr_req), .busy(p_busy)
  );

  task automatic test_reset;
    reset_n = 1'b0; wr_en = 1'b0; clr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = {5'd2, 5'd1};
    p_wr_en = 1'b0; p_clr_req = 1'b0; p_wr_addr = '0; p_wr_data = '0;
    p_rd_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    #12;
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    n_checks++; if (rd_data0 !== 64'h0) begin n_fail++; $display("FAIL reset_rd_comb: got %h expected 0", rd_data0); end
    n_checks++; if (rd_data1 !== 64'h0) begin n_fail++; $display("FAIL reset_rd_reg: got %h expected 0", rd_data1); end
    n_checks++; if (p_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_param: got %h expected 0", p_rd_data); end
    n_checks++; if (p_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_param: got %b expected 0", p_busy); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_write_read;
    @(negedge clk); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd1, 5'd2};
    @(negedge clk); wr_en = 1'b0; rd_addr = {5'd0, 5'd5};
    #1;
    n_checks++; if (rd_data0 !== {32'h0, 32'hDEADBEEF}) begin n_fail++;
      $display("FAIL wr_rd_comb: got %h expected %h", rd_data0, {32'h0, 32'hDEADBEEF}); end
    @(negedge clk);
    n_checks++; if (rd_data1 !== {32'h0, 32'hDEADBEEF}) begin n_fail++;
      $display("FAIL wr_rd_reg: got %h expected %h", rd_data1, {32'h0, 32'hDEADBEEF}); end
  endtask

  task automatic test_zero_reg;
    @(negedge clk); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr = {5'd0, 5'd0};
    #1;
    n_checks++; if (rd_data0 !== 64'h0) begin n_fail++; $display("FAIL zero_bypass: got %h expected 0", rd_data0); end
    @(negedge clk);
    n_checks++; if (rd_data1 !== 64'h0) begin n_fail++; $display("FAIL zero_reg_rd: got %h expected 0", rd_data1); end
    wr_en = 1'b0;
    #1;
    n_checks++; if (rd_data0 !== 64'h0) begin n_fail++; $display("FAIL zero_after: got %h expected 0", rd_data0); end
  endtask

  task automatic test_bypass;
    @(negedge clk); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; rd_addr = {5'd7, 5'd5};
    #1;
    n_checks++; if (rd_data0 !== {32'h12345678, 32'hDEADBEEF}) begin n_fail++;
      $display("FAIL bypass_comb: got %h expected %h", rd_data0, {32'h12345678, 32'hDEADBEEF}); end
    n_checks++; if (rd_data1 !== 64'h0) begin n_fail++;
      $display("FAIL bypass_reg_latency: got %h expected 0", rd_data1); end
    @(negedge clk);
    n_checks++; if (rd_data1 !== {32'h12345678, 32'hDEADBEEF}) begin n_fail++;
      $display("FAIL bypass_reg: got %h expected %h", rd_data1, {32'h12345678, 32'hDEADBEEF}); end
    wr_en = 1'b0; rd_addr = {5'd7, 5'd7};
    #1;
    n_checks++; if (rd_data0 !== {32'h12345678, 32'h12345678}) begin n_fail++;
      $display("FAIL same_addr_ports: got %h expected %h", rd_data0, {32'h12345678, 32'h12345678}); end
  endtask

  task automatic test_clear;
    int cycles;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_addr = i[4:0]; wr_data = 32'h10000000 + 32'(i);
    end
    @(negedge clk); wr_en = 1'b0; clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    cycles = 0;
    while (busy0 === 1'b1 && cycles < 100) begin
      cycles++;
      clr_req = (cycles == 10);
      if (cycles == 20) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFEF00D; rd_addr = {5'd31, 5'd3};
        #1;
        n_checks++; if (rd_data0 !== {32'h1000001F, 32'h0}) begin n_fail++;
          $display("FAIL clear_read_no_bypass: got %h expected %h", rd_data0, {32'h1000001F, 32'h0}); end
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0; clr_req = 1'b0;
    n_checks++; if (cycles != 32) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d expected 32", cycles); end
    for (int i = 0; i < 32; i++) begin
      rd_addr = {i[4:0], i[4:0]};
      #1;
      n_checks++; if (rd_data0 !== 64'h0) begin n_fail++;
        $display("FAIL clear_reg_%0d: got %h expected 0", i, rd_data0); end
      @(negedge clk);
    end
    rd_addr = {5'd0, 5'd3};
    #1;
    n_checks++; if (rd_data0[31:0] !== 32'h0) begin n_fail++;
      $display("FAIL clear_drop_write_reg3: got %h expected 0", rd_data0[31:0]); end
  endtask

  task automatic test_reset_during_clear;
    @(negedge clk); wr_en = 1'b1; wr_addr = 5'd30; wr_data = 32'h00000077;
    @(negedge clk); wr_en = 1'b0; clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL rst_clr_busy_pre: got %b expected 1", busy0); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_clr_busy: got %b expected 0", busy0); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_clr_busy_reg: got %b expected 0", busy1); end
    rd_addr = {5'd30, 5'd30};
    #1;
    n_checks++; if (rd_data0 !== 64'h0) begin n_fail++; $display("FAIL rst_clr_reg30: got %h expected 0", rd_data0); end
    n_checks++; if (rd_data1 !== 64'h0) begin n_fail++; $display("FAIL rst_clr_rd_reg: got %h expected 0", rd_data1); end
    for (int i = 0; i < 32; i++) begin
      rd_addr = {i[4:0], i[4:0]};
      #1;
      n_checks++; if (rd_data0 !== 64'h0) begin n_fail++;
        $display("FAIL rst_clr_reg_%0d: got %h expected 0", i, rd_data0); end
    end
    @(negedge clk); reset_n = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5; rd_addr = {5'd1, 5'd1};
    @(negedge clk); wr_en = 1'b0; rd_addr = {5'd9, 5'd9};
    #1;
    n_checks++; if (rd_data0 !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin n_fail++;
      $display("FAIL post_reset_write: got %h expected %h", rd_data0, {32'hA5A5A5A5, 32'hA5A5A5A5}); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy0); end
  endtask

  task automatic test_param;
    @(negedge clk); p_wr_en = 1'b1; p_wr_addr = 3'd0; p_wr_data = 8'h3C; p_rd_addr = {4{3'd1}};
    @(negedge clk); p_wr_en = 1'b0; p_rd_addr = {4{3'd0}};
    #1;
    n_checks++; if (p_rd_data !== 32'h0) begin n_fail++; $display("FAIL param_latency: got %h expected 0", p_rd_data); end
    @(negedge clk);
    n_checks++; if (p_rd_data !== 32'h3C3C3C3C) begin n_fail++;
      $display("FAIL param_all_ports: got %h expected 3c3c3c3c", p_rd_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_clear();
    test_reset_during_clear();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mux_n.md
REGFILE_MUX_N -- requirements
Module: regfile_mux_n

Interface
- REQ-001: Parameter WIDTH, default 32, data width of each register, in bits.
- REQ-002: Parameter DEPTH, default 32, register count; must be a power of 2 and at least 2.
- REQ-003: Parameter NRD, default 2, number of independent read ports; must be at least 1.
- REQ-004: Parameter ZERO_REG, default 1; when 1, register 0 always reads zero and ignores writes.
- REQ-005: Parameter REG_RD, default 0; 0 gives combinational reads, 1 gives registered reads with 1-cycle latency.
- REQ-006: AW SHALL equal clog2(DEPTH) and is derived, not overridable.
- REQ-007: clk  input  1  the single clock; all state updates on its rising edge.
- REQ-008: reset_n  input  1  asynchronous, active-low reset.
- REQ-009: wr_en  input  1  write request for the current cycle.
- REQ-010: wr_addr  input  AW  write register index.
- REQ-011: wr_data  input  WIDTH  write data.
- REQ-012: rd_addr  input  NRD*AW  packed read indices; port k uses bits [k*AW +: AW].
- REQ-013: rd_data  output  NRD*WIDTH  packed read data; port k uses bits [k*WIDTH +: WIDTH].
- REQ-014: clr_req  input  1  single-cycle pulse that starts a sequenced clear of all registers.
- REQ-015: busy  output  1  high while the clear sequence is running.

Function
- REQ-016: Storage SHALL be DEPTH registers of WIDTH bits.
- REQ-017: A write SHALL commit when the rising edge samples wr_en=1 and busy=0.
- REQ-018: When ZERO_REG=1, writes to address 0 SHALL be dropped, and reads of address 0 SHALL return 0 on every port at all times.
- REQ-019: With REG_RD=0, port k SHALL output the contents of the register at its read address combinationally, in the same cycle.
- REQ-020: Bypass: port k SHALL output wr_data instead of stored contents when all of the following hold:
  - wr_en=1 and busy=0;
  - wr_addr equals that port's read address;
  - the address is not register 0 under ZERO_REG=1.
- REQ-021: With REG_RD=1, rd_data SHALL be captured on each rising edge from the REQ-019/REQ-020 value, giving exactly 1 cycle of latency.
- REQ-022: All NRD ports SHALL operate independently; several ports reading the same address SHALL all return identical data.
- REQ-023: The clear state machine SHALL have two states: IDLE and CLEAR.
- REQ-024: IDLE -> CLEAR SHALL occur on an edge sampling clr_req=1; this also loads the clear counter with 0.
- REQ-025: In CLEAR, each edge SHALL zero the register at the counter index and then increment the counter.
- REQ-026: CLEAR -> IDLE SHALL occur on the edge that zeros index DEPTH-1, so a clear takes exactly DEPTH cycles.
- REQ-027: busy SHALL equal 1 exactly while in CLEAR.
- REQ-028: clr_req sampled while in CLEAR SHALL be ignored and SHALL NOT restart the sequence.
- REQ-029: wr_en asserted while busy=1 SHALL be dropped with no effect and no retry.
- REQ-030: clr_req and wr_en sampled on the same edge in IDLE: the write SHALL commit on that edge, and the clear SHALL start and later zero that register.
- REQ-031: Reads during CLEAR SHALL return current contents (already-cleared indices read 0) with no bypass applied.

Reset
- REQ-032: reset_n=0 SHALL, immediately and independent of clk, zero all registers, force the state to IDLE, zero the clear counter, and drive busy=0.
- REQ-033: With REG_RD=1, reset SHALL also zero the registered rd_data.
- REQ-034: Reset asserted during CLEAR SHALL abort the sequence.
- REQ-035: After reset_n rises, the first edge SHALL accept writes and clr_req normally.

Verification
- REQ-036: Write-then-read, default parameters:
  - stimulus: write reg 5 = 0xDEADBEEF; next cycle set port 0 to addr 5 and port 1 to addr 0;
  - response: port 0 reads 0xDEADBEEF, port 1 reads 0.
- REQ-037: Zero register:
  - stimulus: write addr 0 = 0xFFFFFFFF, with the same-cycle bypass check;
  - response: rd_data for addr 0 stays 0 in that cycle and after.
- REQ-038: Bypass:
  - stimulus: wr_en=1, wr_addr=7, wr_data=0x12345678, with rd_addr port 1 = 7 in the same cycle;
  - response: port 1 reads 0x12345678 in that cycle with REG_RD=0, and one cycle later with REG_RD=1.
- REQ-039: Clear sequence:
  - stimulus: fill regs 1..31 with nonzero data, pulse clr_req;
  - response: busy is high for exactly 32 cycles, and all reads return 0 afterwards;
  - stimulus: attempt a write to reg 3 while busy;
  - response: reg 3 still reads 0 after busy falls.
- REQ-040: Reset during clear:
  - stimulus: assert reset_n=0 at clear cycle 10;
  - response: busy=0 immediately and all registers read 0;
  - stimulus: write reg 9 = 0xA5A5A5A5 on the first edge after release;
  - response: reg 9 reads 0xA5A5A5A5.
- REQ-041: Parametric run:
  - setup: WIDTH=8, DEPTH=8, NRD=4, REG_RD=1, ZERO_REG=0;
  - stimulus: write addr 0 = 0x3C, then read it on all four ports;
  - response: all four ports read 0x3C one cycle after the address is applied.
